// File: rtl/sramgen_sram_masked_init.sv
// sramgen_sram_masked_init
//
// Single-port synchronous SRAM with per-lane write masking and a built-in
// zero-initialisation sequencer.  After every reset the macro walks through
// all RAM_DEPTH words writing zero, one word per clock, while busy is high
// and all requests are ignored.  Once that sweep finishes the memory serves
// reads (one-cycle latency) and masked writes.
//
// Ports:
//   clk        - clock, everything samples on the rising edge
//   rst        - synchronous active-high reset
//   vdd, vss   - power pins, only present when USE_POWER_PINS is defined
//   ce         - chip enable, a request is accepted only when high
//   we         - 1 = write, 0 = read
//   wmask      - per-lane write enable, bit i covers din lane i (lane 0 = LSBs)
//   addr       - word address
//   din        - write data
//   dout       - read data, holds its value between reads
//   dout_valid - high for the cycle after a read was accepted
//   busy       - initialisation in progress, requests are ignored
module sramgen_sram_masked_init #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = 4
) (
`ifdef USE_POWER_PINS
    inout  wire                     vdd,
    inout  wire                     vss,
`endif
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    we,
    input  logic [WMASK_WIDTH-1:0]  wmask,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    busy
);

    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  cnt;
    logic [ADDR_WIDTH-1:0]  cnt_next;
    logic                   rd_accept;
    logic                   wr_accept;

    logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

    // State and init-counter register.  Reset always restarts the clearing
    // sweep from word 0, whether it arrives mid-sweep or in normal operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic.  The counter advances once per cycle in INIT; the
    // edge that clears the last word moves to READY, and the counter wraps
    // back to 0 by natural overflow so it is ready for the next sweep.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            INIT: begin
                cnt_next = cnt + 1'b1;
                if (cnt == {ADDR_WIDTH{1'b1}}) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy      = (state == INIT);
    assign rd_accept = (state == READY) && ce && !we;
    assign wr_accept = (state == READY) && ce && we;

    // Storage.  Nothing is written on a reset edge, so a request pending
    // alongside reset is dropped.  During INIT the sweep owns the array;
    // in READY only the lanes selected by wmask are overwritten, so an
    // all-zero mask behaves as a write that changes nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[cnt] <= '0;
            end else if (wr_accept) begin
                for (int i = 0; i < WMASK_WIDTH; i++) begin
                    if (wmask[i]) begin
                        mem[addr][i*LANE_WIDTH +: LANE_WIDTH] <= din[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    // Read port.  dout only changes on an accepted read and otherwise holds
    // its last value; dout_valid flags exactly the cycles following a read.
    // A read right after a write to the same word sees the merged data
    // because the array was already updated on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_accept;
            if (rd_accept) begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: doc/sramgen_sram_masked_init.md
SRAMGEN_SRAM_MASKED_INIT -- requirements
Module: sramgen_sram_masked_init

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning address width; RAM_DEPTH = 1 << ADDR_WIDTH words.
REQ-003 SHALL have parameter WMASK_WIDTH, default 4, meaning write-mask lanes; DATA_WIDTH must be divisible by WMASK_WIDTH, giving lane width DATA_WIDTH/WMASK_WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic samples on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports vdd and vss, inout, 1 bit each: power and ground, present only under USE_POWER_PINS.
REQ-007 SHALL have port ce, input, 1 bit: chip enable; request accepted only when high.
REQ-008 SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port wmask, input, WMASK_WIDTH bits: per-lane write enable; bit i covers din lane i (lane 0 = LSBs).
REQ-010 SHALL have port addr, input, ADDR_WIDTH bits: word address.
REQ-011 SHALL have port din, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port dout, output reg, DATA_WIDTH bits: read data.
REQ-013 SHALL have port dout_valid, output reg, 1 bit: dout updated by a read at the last edge.
REQ-014 SHALL have port busy, output, 1 bit: initialisation in progress; requests ignored.

Function
REQ-015 SHALL implement a state machine with states INIT and READY, plus an ADDR_WIDTH-bit init counter.
REQ-016 INIT: each edge writes all-zeros to mem[cnt] and increments cnt; at the edge writing cnt == RAM_DEPTH-1, SHALL go to READY and cnt SHALL wrap to 0.
REQ-017 Initialisation SHALL take exactly RAM_DEPTH cycles after rst deasserts; busy SHALL be high in INIT and low in READY.
REQ-018 In INIT, ce/we/wmask/addr/din SHALL be ignored: no memory change, dout holds, dout_valid = 0.
REQ-019 READY read (ce=1, we=0): dout SHALL equal mem[addr] after the next edge (1-cycle latency), with dout_valid = 1 for that one cycle.
REQ-020 READY write (ce=1, we=1): at the edge, each lane i with wmask[i]=1 SHALL take din lane i; lanes with wmask[i]=0 SHALL be unchanged; dout holds; dout_valid = 0.
REQ-021 Write with wmask all-zero SHALL leave memory unchanged and otherwise behave as a write.
REQ-022 ce=0 SHALL cause no memory change; dout holds; dout_valid = 0.
REQ-023 A read of an address written at the immediately preceding edge SHALL return the new merged data (no bypass needed; storage is already updated).
REQ-024 Back-to-back reads SHALL be accepted every cycle; dout_valid stays high while reads continue.

Reset
REQ-025 While rst=1 at an edge: state <= INIT, cnt <= 0, dout <= 0, dout_valid <= 0; memory is not written on that edge.
REQ-026 rst asserted mid-INIT SHALL restart initialisation from address 0; rst in READY SHALL discard any concurrent request and re-clear all memory.
REQ-027 busy SHALL read 1 in the cycle after any reset edge.

Verification
REQ-028 Reset then idle: rst high 1 cycle, low -> busy=1 for exactly 64 cycles, then 0; reads of addresses 0, 31, 63 -> dout=0x00000000, dout_valid=1.
REQ-029 Masked write: write addr 5, din 0xAABBCCDD, wmask 4'b1111; then write addr 5, din 0x11223344, wmask 4'b0101; read addr 5 -> dout=0xAA22CC44 one cycle later.
REQ-030 Ignore while busy: write addr 3, din 0xFFFFFFFF, wmask 4'b1111 during INIT cycle 10 -> after busy falls, read addr 3 -> 0x00000000.
REQ-031 Reset mid-INIT: rst at INIT cycle 40 -> busy stays high for a further 64 cycles from the rst deassert; all words read 0.
REQ-032 Reset in READY: fill addr 0..63 with addr value, pulse rst with a write pending -> after re-init all reads return 0; dout=0 and dout_valid=0 right after reset.
REQ-033 Streaming: reads addr 1,2,3 on consecutive cycles after writes of 0x1,0x2,0x3 -> dout 0x1,0x2,0x3 on consecutive cycles; dout_valid high for 3 cycles then 0; ce=0 cycle holds dout=0x3.
